// File: rtl/imm_encoder.sv
// imm_encoder: finds the smallest even rotation giving an imm8 ROR 2*rot form
// of a 32-bit constant, optionally retrying on its complement (MOV->MVN).
module imm_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] valueIn,
  input  logic        tryInvert,
  output logic        busy,
  output logic        done,
  output logic        encodable,
  output logic        inverted,
  output logic [11:0] data12Out
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    SEARCH_INV,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  r_q, r_d;
  logic [31:0] w_q, w_d;
  logic        ti_q, ti_d;
  logic        enc_q, enc_d;
  logic        inv_q, inv_d;
  logic [11:0] data_q, data_d;
  logic [31:0] rot;
  logic        hit;

  // Rotate-left of w by 2*r; imm8 ROR 2r == w  <=>  w ROL 2r == imm8
  always_comb begin
    rot = w_q;
    case (r_q)
      4'd0:  rot = w_q;
      4'd1:  rot = {w_q[29:0], w_q[31:30]};
      4'd2:  rot = {w_q[27:0], w_q[31:28]};
      4'd3:  rot = {w_q[25:0], w_q[31:26]};
      4'd4:  rot = {w_q[23:0], w_q[31:24]};
      4'd5:  rot = {w_q[21:0], w_q[31:22]};
      4'd6:  rot = {w_q[19:0], w_q[31:20]};
      4'd7:  rot = {w_q[17:0], w_q[31:18]};
      4'd8:  rot = {w_q[15:0], w_q[31:16]};
      4'd9:  rot = {w_q[13:0], w_q[31:14]};
      4'd10: rot = {w_q[11:0], w_q[31:12]};
      4'd11: rot = {w_q[9:0],  w_q[31:10]};
      4'd12: rot = {w_q[7:0],  w_q[31:8]};
      4'd13: rot = {w_q[5:0],  w_q[31:6]};
      4'd14: rot = {w_q[3:0],  w_q[31:4]};
      4'd15: rot = {w_q[1:0],  w_q[31:2]};
      default: rot = w_q;
    endcase
  end

  assign hit = (rot[31:8] == 24'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = SEARCH;
      end
      SEARCH: begin
        if (hit) state_d = DONE;
        else if (r_q == 4'd15) state_d = ti_q ? SEARCH_INV : DONE;
      end
      SEARCH_INV: begin
        if (hit || r_q == 4'd15) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r_d    = r_q;
    w_d    = w_q;
    ti_d   = ti_q;
    enc_d  = enc_q;
    inv_d  = inv_q;
    data_d = data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          w_d  = valueIn;
          ti_d = tryInvert;
          r_d  = 4'd0;
        end
      end
      SEARCH, SEARCH_INV: begin
        if (hit) begin
          enc_d  = 1'b1;
          inv_d  = (state_q == SEARCH_INV);
          data_d = {r_q, rot[7:0]};
        end else if (r_q != 4'd15) begin
          r_d = r_q + 4'd1;
        end else if (state_q == SEARCH && ti_q) begin
          w_d = ~w_q;
          r_d = 4'd0;
        end else begin
          enc_d  = 1'b0;
          inv_d  = 1'b0;
          data_d = 12'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q    <= 4'd0;
      w_q    <= 32'd0;
      ti_q   <= 1'b0;
      enc_q  <= 1'b0;
      inv_q  <= 1'b0;
      data_q <= 12'd0;
    end else begin
      r_q    <= r_d;
      w_q    <= w_d;
      ti_q   <= ti_d;
      enc_q  <= enc_d;
      inv_q  <= inv_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    encodable = enc_q;
    inverted  = inv_q;
    data12Out = data_q;
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: vector table, corner sequences and randomized
// constants checked against a search model of the rotate-immediate rules.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] valueIn = 32'd0;
  logic        tryInvert = 1'b0;
  logic        busy, done, encodable, inverted;
  logic [11:0] data12Out;

  int nerr = 0;
  int nchk = 0;

  imm_encoder dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .valueIn(valueIn),
    .tryInvert(tryInvert),
    .busy(busy),
    .done(done),
    .encodable(encodable),
    .inverted(inverted),
    .data12Out(data12Out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    logic        ti;
    logic        enc;
    logic        inv;
    logic [11:0] data;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] rol32(input logic [31:0] x, input int k);
    int s;
    s = k % 32;
    if (s == 0) return x;
    return (x << s) | (x >> (32 - s));
  endfunction

  // Reference: plain ascending search, direct constant before complement.
  task automatic model(input logic [31:0] v, input logic ti,
                       output logic enc, output logic inv,
                       output logic [11:0] data, output int lat);
    logic [31:0] x, y;
    logic [3:0]  rr;
    enc = 1'b0;
    inv = 1'b0;
    data = 12'd0;
    lat = ti ? 32 : 16;
    for (int p = 0; p < (ti ? 2 : 1); p++) begin
      x = (p == 1) ? ~v : v;
      for (int r = 0; r < 16; r++) begin
        y = rol32(x, 2 * r);
        if (y < 32'h100) begin
          rr = 4'(r);
          enc = 1'b1;
          inv = (p == 1);
          data = {rr, y[7:0]};
          lat = p * 16 + r + 1;
          return;
        end
      end
    end
  endtask

  task automatic run_op(input logic [31:0] v, input logic ti, output int lat);
    start = 1'b1;
    valueIn = v;
    tryInvert = ti;
    @(posedge clk);
    #1;
    start = 1'b0;
    valueIn = $urandom;
    tryInvert = 1'($urandom_range(0, 1));
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_op(input string nm, input logic [31:0] v,
                          input logic ti, input logic ee, input logic ei,
                          input logic [11:0] ed, input int el);
    int lat;
    logic [11:0] d;
    run_op(v, ti, lat);
    chk({nm, ".lat"}, lat, el);
    chk({nm, ".enc"}, encodable, ee);
    chk({nm, ".inv"}, inverted, ei);
    chk({nm, ".data"}, data12Out, ed);
    d = data12Out;
    @(posedge clk);
    #1;
    chk({nm, ".done_low"}, done, 1'b0);
    chk({nm, ".idle"}, busy, 1'b0);
    chk({nm, ".hold"}, data12Out, d);
  endtask

  vec_t vecs[$];

  initial begin
    int          n;
    logic [31:0] v, tv;
    logic        ti, me, mi;
    logic [11:0] md;
    int          ml;
    logic [7:0]  imm;

    vecs.push_back('{32'h00000000, 1'b0, 1'b1, 1'b0, 12'h000, 1});
    vecs.push_back('{32'hFF000000, 1'b0, 1'b1, 1'b0, 12'h4FF, 5});
    vecs.push_back('{32'hF000000F, 1'b0, 1'b1, 1'b0, 12'h2FF, 3});
    vecs.push_back('{32'hFFFFFF00, 1'b1, 1'b1, 1'b1, 12'h0FF, 17});
    vecs.push_back('{32'hFFFFFF00, 1'b0, 1'b0, 1'b0, 12'h000, 16});
    vecs.push_back('{32'h00000101, 1'b1, 1'b0, 1'b0, 12'h000, 32});
    vecs.push_back('{32'h00000FF0, 1'b0, 1'b1, 1'b0, 12'hEFF, 15});
    vecs.push_back('{32'h000000FF, 1'b1, 1'b1, 1'b0, 12'h0FF, 1});
    vecs.push_back('{32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 12'h000, 17});
    vecs.push_back('{32'h3FC00000, 1'b0, 1'b1, 1'b0, 12'h5FF, 6});

    // reset state, and start ignored while reset is held low
    #2;
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.enc", encodable, 1'b0);
    chk("rst.inv", inverted, 1'b0);
    chk("rst.data", data12Out, 12'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.start_ignored", busy, 1'b0);
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i])
      check_op($sformatf("vec%0d", i), vecs[i].v, vecs[i].ti,
               vecs[i].enc, vecs[i].inv, vecs[i].data, vecs[i].lat);

    // failing search with junk start pulses and input churn while busy
    check_op("pre_busy", 32'hFF000000, 1'b0, 1'b1, 1'b0, 12'h4FF, 5);
    start = 1'b1;
    valueIn = 32'h00000101;
    tryInvert = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    while (!done && n < 40) begin
      start = 1'($urandom_range(0, 1));
      valueIn = $urandom;
      tryInvert = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n++;
      if (n == 31) chk("busy.mid", busy, 1'b1);
    end
    start = 1'b0;
    chk("busy.lat", n, 32);
    chk("busy.enc", encodable, 1'b0);
    chk("busy.inv", inverted, 1'b0);
    chk("busy.data", data12Out, 12'd0);
    @(posedge clk);
    #1;

    // reset mid-search aborts immediately with no done pulse
    check_op("pre_rst", 32'hFF000000, 1'b0, 1'b1, 1'b0, 12'h4FF, 5);
    start = 1'b1;
    valueIn = 32'h00000FF0;
    tryInvert = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort.busy", busy, 1'b0);
    chk("abort.done", done, 1'b0);
    chk("abort.enc", encodable, 1'b0);
    chk("abort.inv", inverted, 1'b0);
    chk("abort.data", data12Out, 12'd0);
    n = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    chk("abort.no_done", n, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_op("restart", 32'h00000FF0, 1'b0, 1'b1, 1'b0, 12'hEFF, 15);

    // back-to-back: start held high through DONE, accepted 3 edges apart
    start = 1'b1;
    valueIn = 32'h00000000;
    tryInvert = 1'b0;
    @(posedge clk);
    #1;
    valueIn = 32'hFF000000;
    @(posedge clk);
    #1;
    chk("b2b.done1", done, 1'b1);
    chk("b2b.data1", data12Out, 12'h000);
    @(posedge clk);
    #1;
    chk("b2b.idle", busy, 1'b0);
    @(posedge clk);
    #1;
    chk("b2b.accept", busy, 1'b1);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b.lat2", n, 5);
    chk("b2b.data2", data12Out, 12'h4FF);
    @(posedge clk);
    #1;

    // randomized constants against the reference search
    for (int k = 0; k < 300; k++) begin
      imm = 8'($urandom);
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = rol32({24'd0, imm}, 32 - 2 * int'($urandom_range(0, 15)));
        2: v = ~rol32({24'd0, imm}, 32 - 2 * int'($urandom_range(0, 15)));
        default: v = rol32({23'd0, 1'b1, imm}, int'($urandom_range(0, 31)));
      endcase
      ti = 1'($urandom_range(0, 1));
      model(v, ti, me, mi, md, ml);
      check_op($sformatf("rnd%0d", k), v, ti, me, mi, md, ml);
      if (encodable) begin
        tv = inverted ? ~v : v;
        chk($sformatf("rnd%0d.ror", k),
            rol32({24'd0, data12Out[7:0]}, 32 - 2 * int'(data12Out[11:8])),
            tv);
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 Parameter: none; search covers exactly 16 even rotations (0..30), one rotation tested per clock.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low forces reset state immediately, independent of clk.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 valueIn  input  32  constant to encode; captured on the edge that accepts start.
REQ-006 tryInvert  input  1  permits a second pass on ~valueIn (MOV->MVN substitution); captured with valueIn.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 done  output  1  one-cycle pulse when a result is valid.
REQ-009 encodable  output  1  result flag: constant representable as imm8 ROR 2*rot.
REQ-010 inverted  output  1  result flag: encoding is of ~valueIn, not valueIn.
REQ-011 data12Out  output  12  {rot[3:0], imm8[7:0]}; the 12-bit operand field the operand decoder expands.

Function
REQ-012 States SHALL be IDLE, SEARCH, SEARCH_INV, DONE; 4-bit rotation counter r; 32-bit working register w.
REQ-013 IDLE: start=1 SHALL load w=valueIn, latch tryInvert, clear r, go to SEARCH; start=0 stays IDLE.
REQ-014 SEARCH/SEARCH_INV test each cycle: hit when (w rotated left by 2*r)[31:8]==0.
REQ-015 On hit: data12Out={r, (w ROL 2*r)[7:0]}, encodable=1, inverted=(state==SEARCH_INV), go to DONE.
REQ-016 On miss with r<15: r increments, state unchanged.
REQ-017 Miss at r=15 in SEARCH with latched tryInvert=1: w=~w, r=0, go to SEARCH_INV.
REQ-018 Miss at r=15 in SEARCH with tryInvert=0, or in SEARCH_INV: encodable=0, inverted=0, data12Out=0, go to DONE.
REQ-019 Smallest hitting r SHALL be reported (search ascending; direct pass before inverted pass).
REQ-020 DONE SHALL last exactly one cycle with done=1, then IDLE; done=0 in all other states.
REQ-021 encodable, inverted, data12Out SHALL hold their values from DONE until the next DONE or reset.
REQ-022 Latency, counted in rising edges after the start-accepting edge: direct hit at r -> done rises after edge r+1; inverted hit at r -> after edge 17+r; failure -> after edge 16 (tryInvert=0) or 32 (tryInvert=1).
REQ-023 start while busy (SEARCH, SEARCH_INV, DONE) SHALL be ignored; valueIn/tryInvert changes while busy SHALL not affect the result.
REQ-024 Back-to-back: start high in the cycle after DONE is accepted normally; minimum spacing between accepted starts is 3 edges.
REQ-025 Rotation SHALL wrap around bit 31/bit 0 (circular); r wraps nowhere since the search ends at 15.

Reset
REQ-026 reset low SHALL force state=IDLE, r=0, w=0, busy=0, done=0, encodable=0, inverted=0, data12Out=0 asynchronously.
REQ-027 reset asserted mid-search SHALL abort with no done pulse; first start after release begins a fresh search.
REQ-028 start coincident with reset release edge is ignored when reset is still low at that edge.

Verification
REQ-029 valueIn=0x00000000, tryInvert=0 -> done after edge 1, encodable=1, inverted=0, data12Out=0x000.
REQ-030 valueIn=0xFF000000 -> hit r=4, done after edge 5, data12Out=0x4FF; 0xF000000F -> r=2, data12Out=0x2FF (wrap-around case).
REQ-031 valueIn=0xFFFFFF00, tryInvert=1 -> done after edge 17, encodable=1, inverted=1, data12Out=0x0FF; same with tryInvert=0 -> done after edge 16, encodable=0, data12Out=0x000.
REQ-032 valueIn=0x00000101, tryInvert=1 -> done after edge 32, encodable=0, inverted=0; busy high for 32 cycles; extra start pulses meanwhile ignored.
REQ-033 Start 0x00000FF0, assert reset at edge 2 -> busy/done/outputs 0 immediately, no done pulse; restart after release -> r=14, data12Out=0xEFF, done after edge 15.
REQ-034 Randomised: for every result, bench SHALL check (imm8 ROR 2*rot), inverted as flagged, equals valueIn, rot minimal, and non-encodability by exhaustive reference when encodable=0.
